// File: rtl/alu_sequencer_if.sv
//------------------------------------------------------------------------------
// Module : alu_sequencer_if
// Brief  : Request, operand, function-select and result bundle of the relay-ALU sequencer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface alu_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_fn;
  logic       req_dest;
  logic [7:0] req_b;
  logic [7:0] req_c;
  logic [7:0] op_b;
  logic [7:0] op_c;
  logic       f1;
  logic       f2;
  logic       f3;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic [7:0] result;
  logic       a_load;
  logic       d_load;
  logic       done;
  logic       flag_z;
  logic       flag_c;
  logic       flag_s;

  // Decode/datapath side: issues requests and returns the ALU result.
  modport master (
    output req_valid, req_fn, req_dest, req_b, req_c, alu_out, alu_carry,
    input  req_ready, op_b, op_c, f1, f2, f3, result, a_load, d_load, done,
           flag_z, flag_c, flag_s
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_fn, req_dest, req_b, req_c, alu_out, alu_carry,
    output req_ready, op_b, op_c, f1, f2, f3, result, a_load, d_load, done,
           flag_z, flag_c, flag_s
  );
endinterface

`default_nettype wire

// File: rtl/alu_sequencer.sv
//------------------------------------------------------------------------------
// Module : alu_sequencer
// Brief  : Sequences one relay-ALU operation per request: latch, settle, commit.
//          Optional macro ALU_FAST_NULL_EN lets a NULL op skip the settle phase.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  alu_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [3:0] c_settle_init = SETTLE_CYCLES[3:0];
  localparam logic [2:0] c_fn_add      = 3'b111;
  localparam logic [2:0] c_fn_inc      = 3'b011;

  state_t     r_state;
  logic [3:0] r_count;
  logic [2:0] r_fn;
  logic       r_dest;
  logic [7:0] r_op_b;
  logic [7:0] r_op_c;
  logic [7:0] r_result;
  logic       r_a_load;
  logic       r_d_load;
  logic       r_done;
  logic       r_flag_z;
  logic       r_flag_c;
  logic       r_flag_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= 4'd0;
      r_fn     <= 3'b000;
      r_dest   <= 1'b0;
      r_op_b   <= 8'd0;
      r_op_c   <= 8'd0;
      r_result <= 8'd0;
      r_a_load <= 1'b0;
      r_d_load <= 1'b0;
      r_done   <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_s <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done   <= 1'b0;
          r_a_load <= 1'b0;
          r_d_load <= 1'b0;
          if (bus.req_valid) begin
            r_fn    <= bus.req_fn;
            r_op_b  <= bus.req_b;
            r_op_c  <= bus.req_c;
            r_dest  <= bus.req_dest;
            r_count <= c_settle_init;
`ifdef ALU_FAST_NULL_EN
            if (bus.req_fn == 3'b000) begin
              // Relays stay de-energised, so the result is known without settling.
              r_result <= 8'd0;
              r_flag_z <= 1'b1;
              r_flag_s <= 1'b0;
              r_flag_c <= 1'b0;
              r_done   <= 1'b1;
              r_a_load <= ~bus.req_dest;
              r_d_load <= bus.req_dest;
              r_state  <= COMMIT;
            end else begin
              r_state  <= SETTLE;
            end
`else
            r_state <= SETTLE;
`endif
          end
        end

        SETTLE: begin
          r_count <= r_count - 4'd1;
          if (r_count == 4'd1) begin
            r_result <= bus.alu_out;
            r_flag_z <= (bus.alu_out == 8'd0);
            r_flag_s <= bus.alu_out[7];
            // Carry is only meaningful for the adder-based functions.
            r_flag_c <= ((r_fn == c_fn_add) || (r_fn == c_fn_inc)) ? bus.alu_carry : 1'b0;
            r_done   <= 1'b1;
            r_a_load <= ~r_dest;
            r_d_load <= r_dest;
            r_state  <= COMMIT;
          end
        end

        COMMIT: begin
          r_done   <= 1'b0;
          r_a_load <= 1'b0;
          r_d_load <= 1'b0;
          r_fn     <= 3'b000;
          r_state  <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.f1        = r_fn[2];
  assign bus.f2        = r_fn[1];
  assign bus.f3        = r_fn[0];
  assign bus.op_b      = r_op_b;
  assign bus.op_c      = r_op_c;
  assign bus.result    = r_result;
  assign bus.a_load    = r_a_load;
  assign bus.d_load    = r_d_load;
  assign bus.done      = r_done;
  assign bus.flag_z    = r_flag_z;
  assign bus.flag_c    = r_flag_c;
  assign bus.flag_s    = r_flag_s;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_alu_sequencer
// Brief  : Scoreboard bench for alu_sequencer with a behavioural relay-ALU model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_sequencer;

  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic reset;
  logic carry_noise;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   accepts = 0;
  int   last_acc = 0;
  int   prev_acc = 0;
  logic [2:0] cur_fn = 3'b000;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       s;
    logic       dest;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [8:0] r9;
  logic [8:0] dp;

  alu_sequencer_if bus();

  alu_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {carry, result} of each function, straight from the function table.
  function automatic logic [8:0] ref_alu(input logic [2:0] fn, input logic [7:0] b,
                                         input logic [7:0] c);
    case (fn)
      3'b111:  return {1'b0, b} + {1'b0, c};
      3'b110:  return {1'b0, b ^ c};
      3'b101:  return {1'b0, b & c};
      3'b100:  return {b, 1'b0};
      3'b011:  return {1'b0, b} + 9'd1;
      3'b010:  return {1'b0, ~b};
      3'b001:  return {1'b0, b | c};
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic is_arith(input logic [2:0] fn);
    return (fn == 3'b111) || (fn == 3'b011);
  endfunction

  // Datapath model: non-arithmetic ops present a spurious carry bit.
  always_comb begin
    dp            = ref_alu({bus.f1, bus.f2, bus.f3}, bus.op_b, bus.op_c);
    bus.alu_out   = dp[7:0];
    bus.alu_carry = is_arith({bus.f1, bus.f2, bus.f3}) ? dp[8] : carry_noise;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (!bus.req_ready) check("f_hold", {29'd0, bus.f1, bus.f2, bus.f3}, {29'd0, cur_fn});
      else                check("f_idle", {29'd0, bus.f1, bus.f2, bus.f3}, 32'd0);
      check("strobes", {30'd0, bus.a_load & bus.d_load, (bus.a_load | bus.d_load) ^ bus.done}, 32'd0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("result", {24'd0, bus.result}, {24'd0, e.res});
          check("flags_zcs", {29'd0, bus.flag_z, bus.flag_c, bus.flag_s}, {29'd0, e.z, e.c, e.s});
          check("loads_ad", {30'd0, bus.a_load, bus.d_load}, {30'd0, ~e.dest, e.dest});
          check("done_cycle", cyc, e.cyc);
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        r9     = ref_alu(bus.req_fn, bus.req_b, bus.req_c);
        e.res  = r9[7:0];
        e.z    = (r9[7:0] == 8'd0);
        e.s    = r9[7];
        e.c    = is_arith(bus.req_fn) ? r9[8] : 1'b0;
        e.dest = bus.req_dest;
        e.cyc  = cyc + 1 + SETTLE;
`ifdef ALU_FAST_NULL_EN
        if (bus.req_fn == 3'b000) e.cyc = cyc + 1;
`endif
        sb.push_back(e);
        cur_fn   = bus.req_fn;
        prev_acc = last_acc;
        last_acc = cyc + 1;
        accepts++;
      end
    end
  end

  task automatic drive(input logic [2:0] fn, input logic [7:0] b, input logic [7:0] c,
                       input logic dst, input logic noise);
    bus.req_fn   = fn;
    bus.req_b    = b;
    bus.req_c    = c;
    bus.req_dest = dst;
    carry_noise  = noise;
  endtask

  task automatic wait_accept(input int start);
    int n = 0;
    while (accepts == start && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (accepts == start) check("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !bus.req_ready) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", sb.size(), 32'd0);
  endtask

  task automatic send(input logic [2:0] fn, input logic [7:0] b, input logic [7:0] c,
                      input logic dst, input logic noise);
    int start;
    @(posedge clk); #1;
    start = accepts;
    drive(fn, b, c, dst, noise);
    bus.req_valid = 1'b1;
    wait_accept(start);
    bus.req_valid = 1'b0;
    drain();
  endtask

  initial begin
    int start;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    drive(3'b000, 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset: nothing moves without a request.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_state",
            {17'd0, bus.req_ready, bus.f1, bus.f2, bus.f3, bus.result, bus.flag_z,
             bus.flag_c, bus.flag_s, bus.a_load, bus.d_load, bus.done},
            {17'd0, 1'b1, 3'b000, 8'h00, 6'd0});
    end

    send(3'b111, 8'h7F, 8'h01, 1'b0, 1'b0);   // ADD -> 0x80, S set
    send(3'b011, 8'hFF, 8'h5A, 1'b1, 1'b0);   // INC wraps -> Z and C
    send(3'b101, 8'hF0, 8'h0F, 1'b0, 1'b1);   // AND with spurious carry
    send(3'b000, 8'h33, 8'h44, 1'b1, 1'b1);   // NULL

    // Continuous valid with payload churn while busy.
    @(posedge clk); #1;
    start = accepts;
    bus.req_valid = 1'b1;
    drive(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    for (int n = 0; n < 40 && accepts < start + 2; n++) begin
      @(posedge clk); #1;
      drive(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    bus.req_valid = 1'b0;
    check("b2b_accepts", accepts - start, 32'd2);
    check("b2b_gap", last_acc - prev_acc, SETTLE + 2);
    drain();

    // Abort an XOR on its 2nd settle cycle.
    send(3'b111, 8'h7F, 8'h01, 1'b0, 1'b0);
    @(posedge clk); #1;
    start = accepts;
    drive(3'b110, 8'hA5, 8'h0F, 1'b1, 1'b0);
    bus.req_valid = 1'b1;
    wait_accept(start);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_abort",
          {17'd0, bus.req_ready, bus.f1, bus.f2, bus.f3, bus.result, bus.flag_z,
           bus.flag_c, bus.flag_s, bus.a_load, bus.d_load, bus.done},
          {17'd0, 1'b1, 3'b000, 8'h00, 6'd0});
    repeat (SETTLE + 4) @(negedge clk);
    check("reset_hold", {21'd0, bus.result, bus.flag_z, bus.flag_c, bus.flag_s}, 32'd0);

    for (int i = 0; i < 30; i++)
      send(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    repeat (4) @(posedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
